// File: rtl/flag_pkg.sv
// ---------------------------------------------------------------------------
// flag_pkg
// Shared definitions for the flag/branch unit:
//   br_kind_e   - branch kind encoding on br_kind
//   CC_*        - LEGv8 condition codes carried on br_cond
//   fsm_state_e - branch-unit sequencing states
//   nzvc_t      - flag register layout {N,Z,V,C}
// ---------------------------------------------------------------------------
package flag_pkg;

  typedef enum logic [1:0] {
    BK_BCOND = 2'b00,
    BK_CBZ   = 2'b01,
    BK_CBNZ  = 2'b10,
    BK_B     = 2'b11
  } br_kind_e;

  // Conditions come in complementary pairs: odd codes invert the even code
  // below them, except the final pair which is always taken.
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_HS = 4'h2;
  localparam logic [3:0] CC_LO = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  typedef enum logic [1:0] {
    ST_NOFLAGS = 2'd0,
    ST_READY   = 2'd1,
    ST_HOLD    = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } nzvc_t;

  function automatic nzvc_t pack_flags(input logic n, input logic z,
                                       input logic v, input logic c);
    nzvc_t f;
    f.n = n;
    f.z = z;
    f.v = v;
    f.c = c;
    return f;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational LEGv8 condition evaluation.
// Ports:
//   br_cond [3:0] in  - condition code
//   nzvc    [3:0] in  - flags as {N,Z,V,C}
//   taken         out - 1 when the condition holds
// ---------------------------------------------------------------------------
module cond_eval
  import flag_pkg::*;
(
  input  logic [3:0] br_cond,
  input  logic [3:0] nzvc,
  output logic       taken
);

  nzvc_t f;
  logic  base;
  logic  always_pair;

  assign f = nzvc_t'(nzvc);

  // Evaluate the even member of each pair; the odd member is its inverse.
  always_comb begin
    base = 1'b0;
    unique case (br_cond[3:1])
      CC_EQ[3:1]: base = f.z;
      CC_HS[3:1]: base = f.c;
      CC_MI[3:1]: base = f.n;
      CC_VS[3:1]: base = f.v;
      CC_HI[3:1]: base = f.c & ~f.z;
      CC_GE[3:1]: base = ~(f.n ^ f.v);
      CC_GT[3:1]: base = ~f.z & ~(f.n ^ f.v);
      CC_AL[3:1]: base = 1'b1;
      default:    base = 1'b0;
    endcase
  end

  // AL/NV both branch, so the inversion rule does not apply to that pair.
  assign always_pair = (br_cond[3:1] == CC_AL[3:1]);
  assign taken       = always_pair ? 1'b1 : (base ^ br_cond[0]);

endmodule

// File: rtl/flag_branch_unit.sv
// ---------------------------------------------------------------------------
// flag_branch_unit
// NZVC flag register plus branch resolution with a one-cycle registered
// result. A B.cond issued before any flags have ever been captured stalls
// until the first set_flags, which is then bypassed into the decision.
// Ports:
//   clk                    in  - clock, rising edge
//   reset_n                in  - synchronous active-low reset
//   negative/zero/overflow/carry_out in - live ALU flags
//   set_flags              in  - capture live flags this cycle
//   br_valid / br_ready    in/out - branch request handshake
//   br_kind [1:0]          in  - 00 B.cond, 01 CBZ, 10 CBNZ, 11 B
//   br_cond [3:0]          in  - condition code for B.cond
//   res_valid / res_taken  out - registered decision, one cycle per transfer
//   flags_q [3:0]          out - flag register {N,Z,V,C}
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_NOFLAGS | no flags captured since reset; B.cond cannot resolve yet
// ST_HOLD    | a B.cond is stalled waiting for the first set_flags
// ST_READY   | flags valid; every request accepted immediately
// ---------------------------------------------------------------------------
module flag_branch_unit
  import flag_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       negative,
  input  logic       zero,
  input  logic       overflow,
  input  logic       carry_out,
  input  logic       set_flags,
  input  logic       br_valid,
  output logic       br_ready,
  input  logic [1:0] br_kind,
  input  logic [3:0] br_cond,
  output logic       res_valid,
  output logic       res_taken,
  output logic [3:0] flags_q
);

  fsm_state_e state_q;
  fsm_state_e state_d;
  br_kind_e   kind;
  nzvc_t      live_flags;
  logic [3:0] eff_flags;
  logic       is_bcond;
  logic       cond_taken;
  logic       taken;
  logic       xfer;

  assign kind       = br_kind_e'(br_kind);
  assign is_bcond   = (kind == BK_BCOND);
  assign live_flags = pack_flags(negative, zero, overflow, carry_out);

  // Flags written this cycle are visible to a B.cond in the same cycle.
  assign eff_flags = set_flags ? live_flags : flags_q;

  cond_eval u_cond_eval (
    .br_cond (br_cond),
    .nzvc    (eff_flags),
    .taken   (cond_taken)
  );

  // CBZ/CBNZ test the live zero input directly, never the register.
  always_comb begin
    taken = 1'b0;
    unique case (kind)
      BK_BCOND: taken = cond_taken;
      BK_CBZ:   taken = zero;
      BK_CBNZ:  taken = ~zero;
      BK_B:     taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    br_ready = 1'b1;
    unique case (state_q)
      ST_NOFLAGS: begin
        if (set_flags) begin
          state_d = ST_READY;
        end else if (br_valid && is_bcond) begin
          state_d  = ST_HOLD;
          br_ready = 1'b0;
        end
      end
      ST_HOLD: begin
        // Release the held B.cond in the very cycle flags arrive.
        br_ready = set_flags | (br_valid & ~is_bcond);
        if (set_flags) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_NOFLAGS;
      end
    endcase
  end

  assign xfer = br_valid & br_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_NOFLAGS;
      flags_q   <= 4'b0000;
      res_valid <= 1'b0;
      res_taken <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (set_flags) begin
        flags_q <= live_flags;
      end
      res_valid <= xfer;
      res_taken <= xfer & taken;
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
module tb_flag_branch_unit;

  localparam logic [1:0] K_BCOND = 2'b00;
  localparam logic [1:0] K_CBZ   = 2'b01;
  localparam logic [1:0] K_CBNZ  = 2'b10;
  localparam logic [1:0] K_B     = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       negative, zero, overflow, carry_out;
  logic       set_flags;
  logic       br_valid;
  logic       br_ready;
  logic [1:0] br_kind;
  logic [3:0] br_cond;
  logic       res_valid;
  logic       res_taken;
  logic [3:0] flags_q;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0] m_flags    = 4'b0000;
  logic       have_flags = 1'b0;
  logic       stalled    = 1'b0;
  logic       exp_valid  = 1'b0;
  logic       exp_taken  = 1'b0;

  always #5 clk = ~clk;

  flag_branch_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out),
    .set_flags (set_flags),
    .br_valid  (br_valid),
    .br_ready  (br_ready),
    .br_kind   (br_kind),
    .br_cond   (br_cond),
    .res_valid (res_valid),
    .res_taken (res_taken),
    .flags_q   (flags_q)
  );

  // Condition table written straight from the LEGv8 definitions.
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, v, c;
    {n, z, v, c} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !(c && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic sf, input logic [3:0] f,
                       input logic bv, input logic [1:0] k, input logic [3:0] cc);
    reset_n   = rn;
    set_flags = sf;
    {negative, zero, overflow, carry_out} = f;
    br_valid  = bv;
    br_kind   = k;
    br_cond   = cc;
  endtask

  // One clock: check br_ready mid-cycle, then registered outputs after the edge.
  task automatic step();
    logic       exp_ready;
    logic       xfer;
    logic       tk;
    logic [3:0] live;
    logic [3:0] eff;
    @(negedge clk);
    live = {negative, zero, overflow, carry_out};
    if (stalled)
      exp_ready = set_flags || (br_valid && br_kind != K_BCOND);
    else
      exp_ready = have_flags || set_flags || !(br_valid && br_kind == K_BCOND);
    if (reset_n) chk("br_ready", {3'b0, br_ready}, {3'b0, exp_ready});
    eff = set_flags ? live : m_flags;
    case (br_kind)
      K_BCOND: tk = ref_cond(br_cond, eff);
      K_CBZ:   tk = zero;
      K_CBNZ:  tk = !zero;
      default: tk = 1'b1;
    endcase
    xfer = reset_n && br_valid && exp_ready;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      m_flags    = 4'b0000;
      have_flags = 1'b0;
      stalled    = 1'b0;
      exp_valid  = 1'b0;
      exp_taken  = 1'b0;
    end else begin
      if (set_flags) begin
        m_flags    = live;
        have_flags = 1'b1;
      end
      stalled   = br_valid && !exp_ready;
      exp_valid = xfer;
      exp_taken = tk;
    end
    chk("res_valid", {3'b0, res_valid}, {3'b0, exp_valid});
    if (exp_valid) chk("res_taken", {3'b0, res_taken}, {3'b0, exp_taken});
    chk("flags_q", flags_q, m_flags);
  endtask

  initial begin
    logic       rn, sf, bv;
    logic [1:0] k;
    logic [3:0] cc;

    drive(1'b0, 1'b0, 4'h0, 1'b0, K_B, 4'h0);

    // reset state
    drive(1'b0, 1'b1, 4'hF, 1'b1, K_B, 4'h0);
    step();
    chk("rst_flags", flags_q, 4'b0000);
    chk("rst_valid", {3'b0, res_valid}, 4'h0);
    drive(1'b0, 1'b0, 4'h0, 1'b0, K_B, 4'h0);
    step();

    // bypass: first flags arrive together with B.cond EQ
    drive(1'b1, 1'b1, 4'b0101, 1'b1, K_BCOND, 4'h0);
    step();
    chk("bypass_valid", {3'b0, res_valid}, 4'h1);
    chk("bypass_taken", {3'b0, res_taken}, 4'h1);
    chk("bypass_flags", flags_q, 4'b0101);

    // signed/unsigned split with N=1,V=0
    drive(1'b1, 1'b1, 4'b1000, 1'b0, K_B, 4'h0);
    step();
    drive(1'b1, 1'b0, 4'h0, 1'b1, K_BCOND, 4'hA);
    step();
    chk("ge_taken", {3'b0, res_taken}, 4'h0);
    drive(1'b1, 1'b0, 4'h0, 1'b1, K_BCOND, 4'hB);
    step();
    chk("lt_taken", {3'b0, res_taken}, 4'h1);
    drive(1'b1, 1'b0, 4'h0, 1'b1, K_BCOND, 4'h2);
    step();
    chk("hs_taken", {3'b0, res_taken}, 4'h0);
    chk("hs_valid", {3'b0, res_valid}, 4'h1);

    // stall path: B.cond NE after reset, no flags for 5 cycles
    drive(1'b0, 1'b0, 4'h0, 1'b0, K_B, 4'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 4'h4, 1'b1, K_BCOND, 4'h1);
      step();
      chk("stall_valid", {3'b0, res_valid}, 4'h0);
    end
    drive(1'b1, 1'b1, 4'b0000, 1'b1, K_BCOND, 4'h1);
    step();
    chk("release_valid", {3'b0, res_valid}, 4'h1);
    chk("release_taken", {3'b0, res_taken}, 4'h1);

    // no-flags paths: CBZ/CBNZ straight after reset
    drive(1'b0, 1'b0, 4'h0, 1'b0, K_B, 4'h0);
    step();
    drive(1'b1, 1'b0, 4'b0100, 1'b1, K_CBZ, 4'h0);
    step();
    chk("cbz_taken", {3'b0, res_taken}, 4'h1);
    drive(1'b1, 1'b0, 4'b0100, 1'b1, K_CBNZ, 4'h0);
    step();
    chk("cbnz_taken", {3'b0, res_taken}, 4'h0);
    chk("cbnz_valid", {3'b0, res_valid}, 4'h1);
    chk("noflags_kept", flags_q, 4'b0000);

    // still without flags: B.cond stalls (enters hold), then reset mid-hold
    drive(1'b1, 1'b0, 4'h0, 1'b1, K_BCOND, 4'hE);
    step();
    step();
    drive(1'b0, 1'b0, 4'h0, 1'b1, K_BCOND, 4'hE);
    step();
    drive(1'b1, 1'b0, 4'h0, 1'b0, K_B, 4'h0);
    step();
    chk("rst_hold_valid", {3'b0, res_valid}, 4'h0);
    chk("rst_hold_flags", flags_q, 4'b0000);
    // back in NOFLAGS: a fresh B.cond must stall again
    drive(1'b1, 1'b0, 4'h0, 1'b1, K_BCOND, 4'hE);
    step();
    drive(1'b1, 1'b1, 4'h3, 1'b1, K_BCOND, 4'hE);
    step();

    // full sweep: every NZVC against every condition, back-to-back
    for (int f = 0; f < 16; f++) begin
      drive(1'b1, 1'b1, 4'(f), 1'b0, K_B, 4'h0);
      step();
      for (int c = 0; c < 16; c++) begin
        drive(1'b1, 1'b0, 4'($urandom), 1'b1, K_BCOND, 4'(c));
        step();
      end
    end

    // randomized traffic, including occasional resets
    for (int i = 0; i < 600; i++) begin
      rn = ($urandom_range(0, 49) != 0);
      sf = ($urandom_range(0, 9) < 3);
      if (stalled) begin
        bv = br_valid;
        k  = br_kind;
        cc = br_cond;
      end else begin
        bv = ($urandom_range(0, 9) < 7);
        k  = 2'($urandom);
        cc = 4'($urandom);
      end
      drive(rn, sf, 4'($urandom), bv, k, cc);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-003 SHALL have inputs negative, zero, overflow, carry_out, each 1 bit; the ALU flags of the current cycle.
REQ-004 SHALL have input set_flags, 1; capture the ALU flags into the NZVC register this cycle.
REQ-005 SHALL have input br_valid, 1, and output br_ready, 1; branch-request handshake.
REQ-006 SHALL have input br_kind, 2, with 00=B.cond, 01=CBZ, 10=CBNZ, 11=B (unconditional).
REQ-007 SHALL have input br_cond, 4; the LEGv8 condition code, used only for B.cond.
REQ-008 SHALL have outputs res_valid, 1, and res_taken, 1; registered branch decision.
REQ-009 SHALL have output flags_q, 4; the NZVC register as {N,Z,V,C}.

Function
REQ-010 SHALL transfer a request when br_valid and br_ready are both 1 at a rising edge.
REQ-011 SHALL assert res_valid for exactly one cycle, in the cycle after a transfer (latency 1), with res_taken valid in that same cycle.
REQ-012 SHALL load flags_q from {negative,zero,overflow,carry_out} on every edge with set_flags=1, and otherwise hold it.
REQ-013 SHALL evaluate B.cond against effective flags, defined as:
- the live ALU flags when set_flags=1 in the transfer cycle (bypass);
- otherwise flags_q.
REQ-014 SHALL decode br_cond as:
- 0 EQ: Z; 1 NE: !Z
- 2 HS: C; 3 LO: !C
- 4 MI: N; 5 PL: !N
- 6 VS: V; 7 VC: !V
- 8 HI: C&!Z; 9 LS: !(C&!Z)
- A GE: N==V; B LT: N!=V
- C GT: !Z&(N==V); D LE: !(!Z&(N==V))
- E, F: always taken.
REQ-015 SHALL compute CBZ taken = live zero input and CBNZ taken = !zero, regardless of set_flags or flags_q.
REQ-016 SHALL make B always taken.
REQ-017 SHALL run an FSM with states NOFLAGS, READY and HOLD.
REQ-018 SHALL use these FSM transitions:
- NOFLAGS to READY on set_flags=1.
- NOFLAGS to HOLD when br_valid=1, br_kind=00 and set_flags=0.
- HOLD to READY on set_flags=1.
- READY is absorbing until reset.
REQ-019 SHALL drive br_ready=0 only in HOLD, and in NOFLAGS when br_valid=1, br_kind=00 and set_flags=0.
REQ-020 SHALL accept CBZ, CBNZ and B immediately in every state, including NOFLAGS.
REQ-021 SHALL, in HOLD, keep the held request stalled; the requester holds br_valid, br_kind and br_cond stable.
REQ-022 SHALL, in HOLD, accept the request in the set_flags cycle using the bypassed flags (REQ-013).
REQ-023 SHALL never produce two res_valid pulses for one transfer, and SHALL accept back-to-back transfers at one per cycle.

Reset
REQ-024 SHALL, while reset_n=0 at an edge, set:
- flags_q=0000, FSM=NOFLAGS;
- res_valid=0, res_taken=0;
- br_ready per REQ-019 evaluated in NOFLAGS.
REQ-025 SHALL, when reset is asserted mid-HOLD, discard the pending request and produce no res_valid for it.
REQ-026 SHALL ignore set_flags and br_valid in any cycle with reset_n=0.

Structure
REQ-027 SHALL take the br_kind encodings, the condition-code constants and the FSM state enum from a shared package, flag_pkg.
REQ-028 SHALL have one sub-module, cond_eval, that is purely combinational: (br_cond, NZVC) -> taken.
REQ-029 SHALL hold the FSM, flag register, bypass mux and output register in flag_branch_unit.

Verification
REQ-030 SHALL cover the bypass case:
- Stimulus: reset, then set_flags=1 with N=0,Z=1,V=0,C=1 while br_valid=1, B.cond EQ.
- Response: br_ready=1; next cycle res_valid=1, res_taken=1, flags_q=0101.
REQ-031 SHALL cover the signed/unsigned split:
- Stimulus: flags_q=1000 (N=1,V=0), B.cond GE then LT then HS on consecutive cycles.
- Response: res_taken=0,1,0 on three consecutive res_valid pulses.
REQ-032 SHALL cover the stall path:
- Stimulus: after reset, B.cond NE with no set_flags for 5 cycles.
- Response: br_ready=0 and res_valid=0 throughout.
- Then set_flags with Z=0; response: transfer that cycle, res_taken=1 next cycle.
REQ-033 SHALL cover the no-flags paths:
- Stimulus: after reset, CBZ with zero=1, then CBNZ with zero=1.
- Response: both accepted immediately; res_taken=1 then 0; FSM stays NOFLAGS.
REQ-034 SHALL cover reset during stall:
- Stimulus: enter HOLD, assert reset_n=0 for one cycle, drop br_valid.
- Response: flags_q=0000, no res_valid for the pending request, FSM=NOFLAGS.
REQ-035 SHALL sweep all 16 br_cond values against all 16 NZVC values and compare res_taken with an independent model.
